// File: rtl/adex_tdm_scheduler_pkg.sv
// Shared definitions for the AdEx time-multiplexed scheduler: state word format,
// default membrane reset value and sweep FSM encoding.
package adex_tdm_scheduler_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC   = 12;   // Q4.12 fractional bits of V and w

    localparam logic [DATA_W-1:0] V_INIT_DEFAULT = 16'hB000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/adex_spike_fifo.sv
// Small synchronous FIFO of spiking neuron indices. Occupancy counter drives
// full/empty; a push on a full FIFO is only accepted when a pop frees the slot.
module adex_spike_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic         dropped
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dropped = push && !do_push;
    assign dout    = mem[rd_ptr];

    // NOTE: storage is not reset; entries are only read once the counter says they were written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adex_tdm_scheduler.sv
// Sweeps N_NEURONS virtual neurons through one shared AdEx core per timestep,
// writing results back to a local V/w register file and logging spikes.
module adex_tdm_scheduler #(
    parameter int                 N_NEURONS  = 4,
    parameter int                 IDX_W      = 2,
    parameter int                 DATA_W     = adex_tdm_scheduler_pkg::DATA_W,
    parameter int                 FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0]  V_INIT     = adex_tdm_scheduler_pkg::V_INIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              enable,
    input  logic              init,
    output logic              core_valid,
    input  logic              core_ready,
    output logic [IDX_W-1:0]  core_idx,
    output logic [DATA_W-1:0] core_v,
    output logic [DATA_W-1:0] core_w,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_v,
    input  logic [DATA_W-1:0] res_w,
    input  logic              res_spike,
    output logic              spk_valid,
    output logic [IDX_W-1:0]  spk_idx,
    input  logic              spk_pop,
    output logic              busy,
    output logic              overrun,
    output logic              spk_drop,
    input  logic              flag_clr,
    output logic [15:0]       step_cnt
);

    import adex_tdm_scheduler_pkg::*;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] v_mem [N_NEURONS];
    logic [DATA_W-1:0] w_mem [N_NEURONS];
    logic              last_idx;
    logic              result_take;
    logic              tick_dropped;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_dropped;

    assign last_idx     = (idx == IDX_W'(N_NEURONS - 1));
    assign result_take  = (state == S_WAIT) && res_valid;
    assign tick_dropped = tick && (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // init takes priority over tick in IDLE, so a coincident tick is silently dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!init && tick && enable) state_nxt = S_ISSUE;
            S_ISSUE: if (core_ready)              state_nxt = S_WAIT;
            S_WAIT:  if (res_valid)               state_nxt = last_idx ? S_DONE : S_ISSUE;
            S_DONE:                               state_nxt = S_IDLE;
            default:                              state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        core_valid = (state == S_ISSUE);
        busy       = (state != S_IDLE);
    end

    assign core_idx = idx;
    assign core_v   = v_mem[idx];
    assign core_w   = w_mem[idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            step_cnt <= '0;
            overrun  <= 1'b0;
            spk_drop <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                v_mem[i] <= V_INIT;
                w_mem[i] <= '0;
            end
        end else begin
            if (state == S_IDLE && init) begin
                for (int i = 0; i < N_NEURONS; i++) begin
                    v_mem[i] <= V_INIT;
                    w_mem[i] <= '0;
                end
            end
            if (state == S_IDLE && !init && tick && enable) idx <= '0;
            if (result_take) begin
                v_mem[idx] <= res_v;
                w_mem[idx] <= res_w;
                if (!last_idx) idx <= idx + IDX_W'(1);
            end
            if (state == S_DONE) step_cnt <= step_cnt + 16'd1;
            // A new event in the same cycle as flag_clr keeps the flag set.
            overrun  <= (overrun  && !flag_clr) || tick_dropped;
            spk_drop <= (spk_drop && !flag_clr) || fifo_dropped;
        end
    end

    adex_spike_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (IDX_W)
    ) u_spike_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (result_take && res_spike),
        .din     (idx),
        .pop     (spk_pop),
        .dout    (spk_idx),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .dropped (fifo_dropped)
    );

    assign spk_valid = !fifo_empty;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule
